lag_max_search: RTL and testbench

- Parametrised open-loop pitch lag search engine for the speech-codec pitch path.
- Sweeps lags from lag_max down to lag_min in steps of lag_step. For each lag, computes the correlation of a frame with its lag-delayed copy through a single shared sample-memory read port.
- Tracks the maximum correlation and its lag, then computes the delayed-frame energy at the winning lag.
- Arithmetic is self-contained (internal saturating MAC); results go to the downstream normalisation stage.

---
 rtl/lag_max_search_pkg.sv | 39 +++
 rtl/lag_max_search_sat_mac.sv | 40 ++++
 rtl/lag_max_search.sv | 230 +++++++++++++++++++++++
 tb/tb_lag_max_search.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lag_max_search_pkg.sv
// Shared types and helpers for the open-loop pitch lag search engine.
// The state encoding and saturation limits are common to the top and its MAC.
package lag_search_pkg;

  typedef enum logic [3:0] {
    IDLE,
    CHK,
    LAG_INIT,
    RD_X,
    WAIT_X,
    RD_Y,
    WAIT_Y,
    MAC,
    LAG_END,
    EN_INIT,
    EN_RD,
    EN_WAIT,
    EN_MAC,
    FIN
  } state_t;

  // Bit patterns of the most negative / most positive acc_w-bit values; the
  // caller truncates them to its accumulator width.
  function automatic logic [63:0] acc_min_bits(input int acc_w);
    return 64'd1 << (acc_w - 1);
  endfunction

  function automatic logic [63:0] acc_max_bits(input int acc_w);
    return (64'd1 << (acc_w - 1)) - 64'd1;
  endfunction

  function automatic logic cfg_invalid(input int unsigned l_frame,
                                       input int unsigned lag_min,
                                       input int unsigned lag_max,
                                       input int unsigned lag_step);
    return (lag_min > lag_max) || (l_frame == 0) || (lag_step == 0);
  endfunction

endpackage

// File: rtl/lag_max_search_sat_mac.sv
// Combinational saturating multiply-accumulate: y = sat(acc + 2*a*b).
// Shared by the correlation and energy phases of lag_max_search.
module sat_mac
  import lag_search_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32
) (
  input  logic signed [ACC_W-1:0]  acc,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  y
);

  localparam int PW = 2 * DATA_W;
  localparam logic signed [ACC_W-1:0]  ACC_MIN = ACC_W'(acc_min_bits(ACC_W));
  localparam logic signed [ACC_W-1:0]  ACC_MAX = ACC_W'(acc_max_bits(ACC_W));
  localparam logic signed [DATA_W-1:0] D_MIN   = {1'b1, {(DATA_W-1){1'b0}}};

  logic signed [PW-1:0]  prod;
  logic signed [ACC_W-1:0] term;
  logic        [ACC_W:0] sum;

  always_comb begin
    prod = PW'(a) * PW'(b);
    // min*min doubled is the one product that does not fit; it clamps first.
    if (a == D_MIN && b == D_MIN) begin
      term = ACC_MAX;
    end else begin
      term = ACC_W'(prod <<< 1);
    end
    sum = {acc[ACC_W-1], acc} + {term[ACC_W-1], term};
    if (sum[ACC_W] != sum[ACC_W-1]) begin
      y = sum[ACC_W] ? ACC_MIN : ACC_MAX;
    end else begin
      y = sum[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/lag_max_search.sv
// Open-loop pitch lag search: sweeps lags lag_max..lag_min, keeps the best
// correlation and its lag, then measures the delayed-frame energy at that lag.
module lag_max_search
  import lag_search_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ACC_W   = 32,
  parameter int ADDR_W  = 12,
  parameter int LAG_W   = 8,
  parameter int RD_LAT  = 1,
  parameter int TIE_LOW = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        sig_base,
  input  logic [LAG_W-1:0]         l_frame,
  input  logic [LAG_W-1:0]         lag_min,
  input  logic [LAG_W-1:0]         lag_max,
  input  logic [LAG_W-1:0]         lag_step,
  output logic                     mem_rd_en,
  output logic [ADDR_W-1:0]        mem_rd_addr,
  input  logic signed [DATA_W-1:0] mem_rd_data,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic signed [ACC_W-1:0]  cor_max,
  output logic [LAG_W-1:0]         p_max,
  output logic signed [ACC_W-1:0]  ener_max
);

  localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(acc_min_bits(ACC_W));
  localparam int WC_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [WC_W-1:0] WAIT_LOAD = WC_W'(RD_LAT - 1);

  state_t                   state_reg;
  logic [ADDR_W-1:0]        base_reg;
  logic [LAG_W-1:0]         lf_reg, lmin_reg, lmax_reg, lstep_reg;
  logic [LAG_W-1:0]         lag_reg, best_reg, n_reg;
  logic [WC_W-1:0]          wait_reg;
  logic signed [DATA_W-1:0] x_reg, y_reg;
  logic signed [ACC_W-1:0]  acc_reg, max_reg;

  logic signed [DATA_W-1:0] mac_a;
  logic signed [ACC_W-1:0]  mac_out;
  logic [LAG_W-1:0]         n_inc;
  logic                     n_last, lag_more, upd, start_bad;

  function automatic logic [ADDR_W-1:0] sample_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [LAG_W-1:0]  n,
                                                    input logic [LAG_W-1:0]  lag);
    return base + ADDR_W'(n) - ADDR_W'(lag);
  endfunction

  // Energy squares the delayed sample, so both MAC operands come from y_reg.
  assign mac_a     = (state_reg == EN_MAC) ? y_reg : x_reg;
  assign n_inc     = n_reg + LAG_W'(1);
  assign n_last    = (n_reg == lf_reg - LAG_W'(1));
  assign lag_more  = (lag_reg >= lstep_reg) && ((lag_reg - lstep_reg) >= lmin_reg);
  assign upd       = (TIE_LOW != 0) ? (acc_reg >= max_reg) : (acc_reg > max_reg);
  assign start_bad = cfg_invalid(32'(l_frame), 32'(lag_min), 32'(lag_max), 32'(lag_step));

  sat_mac #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W)
  ) u_sat_mac (
    .acc(acc_reg),
    .a  (mac_a),
    .b  (y_reg),
    .y  (mac_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      base_reg    <= '0;
      lf_reg      <= '0;
      lmin_reg    <= '0;
      lmax_reg    <= '0;
      lstep_reg   <= '0;
      lag_reg     <= '0;
      best_reg    <= '0;
      n_reg       <= '0;
      wait_reg    <= '0;
      x_reg       <= '0;
      y_reg       <= '0;
      acc_reg     <= '0;
      max_reg     <= ACC_MIN;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      cor_max     <= ACC_MIN;
      p_max       <= '0;
      ener_max    <= '0;
    end else begin
      done      <= 1'b0;
      mem_rd_en <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            base_reg  <= sig_base;
            lf_reg    <= l_frame;
            lmin_reg  <= lag_min;
            lmax_reg  <= lag_max;
            lstep_reg <= lag_step;
            state_reg <= CHK;
            // A bad configuration is reported while sitting in CHK.
            if (start_bad) begin
              done     <= 1'b1;
              err      <= 1'b1;
              busy     <= 1'b0;
              p_max    <= lag_max;
              cor_max  <= ACC_MIN;
              ener_max <= '0;
            end else begin
              busy <= 1'b1;
            end
          end
        end
        CHK: begin
          lag_reg   <= lmax_reg;
          best_reg  <= lmax_reg;
          max_reg   <= ACC_MIN;
          n_reg     <= '0;
          acc_reg   <= '0;
          state_reg <= busy ? LAG_INIT : IDLE;
        end
        LAG_INIT: begin
          mem_rd_en   <= 1'b1;
          mem_rd_addr <= sample_addr(base_reg, n_reg, '0);
          state_reg   <= RD_X;
        end
        RD_X: begin
          wait_reg  <= WAIT_LOAD;
          state_reg <= WAIT_X;
        end
        WAIT_X: begin
          if (wait_reg == '0) begin
            x_reg       <= mem_rd_data;
            mem_rd_en   <= 1'b1;
            mem_rd_addr <= sample_addr(base_reg, n_reg, lag_reg);
            state_reg   <= RD_Y;
          end else begin
            wait_reg <= wait_reg - WC_W'(1);
          end
        end
        RD_Y: begin
          wait_reg  <= WAIT_LOAD;
          state_reg <= WAIT_Y;
        end
        WAIT_Y: begin
          if (wait_reg == '0) begin
            y_reg     <= mem_rd_data;
            state_reg <= MAC;
          end else begin
            wait_reg <= wait_reg - WC_W'(1);
          end
        end
        MAC: begin
          acc_reg <= mac_out;
          if (n_last) begin
            state_reg <= LAG_END;
          end else begin
            n_reg       <= n_inc;
            mem_rd_en   <= 1'b1;
            mem_rd_addr <= sample_addr(base_reg, n_inc, '0);
            state_reg   <= RD_X;
          end
        end
        LAG_END: begin
          if (upd) begin
            max_reg  <= acc_reg;
            best_reg <= lag_reg;
          end
          n_reg   <= '0;
          acc_reg <= '0;
          if (lag_more) begin
            lag_reg   <= lag_reg - lstep_reg;
            state_reg <= LAG_INIT;
          end else begin
            state_reg <= EN_INIT;
          end
        end
        EN_INIT: begin
          mem_rd_en   <= 1'b1;
          mem_rd_addr <= sample_addr(base_reg, n_reg, best_reg);
          state_reg   <= EN_RD;
        end
        EN_RD: begin
          wait_reg  <= WAIT_LOAD;
          state_reg <= EN_WAIT;
        end
        EN_WAIT: begin
          if (wait_reg == '0) begin
            y_reg     <= mem_rd_data;
            state_reg <= EN_MAC;
          end else begin
            wait_reg <= wait_reg - WC_W'(1);
          end
        end
        EN_MAC: begin
          acc_reg <= mac_out;
          if (n_last) begin
            done      <= 1'b1;
            err       <= 1'b0;
            busy      <= 1'b0;
            cor_max   <= max_reg;
            p_max     <= best_reg;
            ener_max  <= mac_out;
            state_reg <= FIN;
          end else begin
            n_reg       <= n_inc;
            mem_rd_en   <= 1'b1;
            mem_rd_addr <= sample_addr(base_reg, n_inc, best_reg);
            state_reg   <= EN_RD;
          end
        end
        FIN: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lag_max_search.sv
// Directed bench for lag_max_search: expected results are queued at start and
// checked by a monitor on every done pulse.
module tb_lag_max_search;

  localparam int NI = 3;

  typedef struct {
    int          inst;
    logic        err;
    logic [31:0] cor;
    logic [7:0]  p;
    logic [31:0] ener;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_v [NI];
  logic [11:0] sig_base;
  logic [7:0]  l_frame, lag_min, lag_max, lag_step;

  logic        rd_en_v   [NI];
  logic [11:0] rd_addr_v [NI];
  logic [15:0] rd_data_v [NI];
  logic        busy_v    [NI];
  logic        done_v    [NI];
  logic        err_v     [NI];
  logic [31:0] cor_v     [NI];
  logic [7:0]  p_v       [NI];
  logic [31:0] ener_v    [NI];
  int          rd_cnt_v  [NI];
  int          done_cnt_v[NI];
  int          proto_v   [NI];

  logic [15:0] mem [4096];
  exp_t        exp_q [$];
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clk = ~clk;

  // Instance 0: RD_LAT=1 TIE_LOW=1, instance 1: TIE_LOW=0, instance 2: RD_LAT=3.
  for (genvar gi = 0; gi < NI; gi++) begin : g_inst
    localparam int RL = (gi == 2) ? 3 : 1;
    localparam int TL = (gi == 1) ? 0 : 1;
    logic        vpipe [RL] = '{default: 1'b0};
    logic [15:0] dpipe [RL] = '{default: 16'h0};
    logic        pend;
    int          rd_cnt   = 0;
    int          done_cnt = 0;
    int          proto    = 0;

    lag_max_search #(
      .DATA_W (16),
      .ACC_W  (32),
      .ADDR_W (12),
      .LAG_W  (8),
      .RD_LAT (RL),
      .TIE_LOW(TL)
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start_v[gi]),
      .sig_base   (sig_base),
      .l_frame    (l_frame),
      .lag_min    (lag_min),
      .lag_max    (lag_max),
      .lag_step   (lag_step),
      .mem_rd_en  (rd_en_v[gi]),
      .mem_rd_addr(rd_addr_v[gi]),
      .mem_rd_data(rd_data_v[gi]),
      .busy       (busy_v[gi]),
      .done       (done_v[gi]),
      .err        (err_v[gi]),
      .cor_max    (cor_v[gi]),
      .p_max      (p_v[gi]),
      .ener_max   (ener_v[gi])
    );

    always_comb begin
      pend = 1'b0;
      for (int k = 0; k < RL; k++) pend = pend | vpipe[k];
    end

    // Read data is only meaningful in the exact return cycle; garbage otherwise.
    always @(posedge clk) begin
      if (rd_en_v[gi]) begin
        rd_cnt <= rd_cnt + 1;
        if (pend) proto <= proto + 1;
      end
      vpipe[0] <= rd_en_v[gi];
      dpipe[0] <= mem[rd_addr_v[gi]];
      for (int k = 1; k < RL; k++) begin
        vpipe[k] <= vpipe[k-1];
        dpipe[k] <= dpipe[k-1];
      end
    end

    always @(negedge clk) begin
      if (done_v[gi]) done_cnt <= done_cnt + 1;
    end

    assign rd_data_v[gi]  = vpipe[RL-1] ? dpipe[RL-1] : 16'h5A5A;
    assign rd_cnt_v[gi]   = rd_cnt;
    assign done_cnt_v[gi] = done_cnt;
    assign proto_v[gi]    = proto;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic exp_t mk(input int inst, input logic err, input logic [31:0] cor,
                              input logic [7:0] p, input logic [31:0] ener);
    exp_t e;
    e.inst = inst;
    e.err  = err;
    e.cor  = cor;
    e.p    = p;
    e.ener = ener;
    return e;
  endfunction

  function automatic int bound_f(input int n, input int l, input int rl);
    return n * (l * (2 * rl + 3) + 2) + l * (rl + 2) + 2 + 3;
  endfunction

  task automatic fill(input int mode);
    for (int k = 0; k < 4096; k++) begin
      case (mode)
        0:       mem[k] = (k % 3 == 0) ? 16'd1000 : 16'd0;
        1:       mem[k] = 16'd0;
        default: mem[k] = 16'h8000;
      endcase
    end
  endtask

  // Scoreboard monitor: one line per completed transaction.
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < NI; k++) begin
      if (done_v[k]) begin
        $display("inst %0d done: err=%0d cor_max=0x%08h p_max=%0d ener_max=0x%08h",
                 k, err_v[k], cor_v[k], p_v[k], ener_v[k]);
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_done: inst %0d pulsed done, expected none", k);
        end else begin
          e = exp_q.pop_front();
          check("mon_inst",     64'(k),         64'(e.inst));
          check("mon_err",      64'(err_v[k]),  64'(e.err));
          check("mon_cor_max",  64'(cor_v[k]),  64'(e.cor));
          check("mon_p_max",    64'(p_v[k]),    64'(e.p));
          check("mon_ener_max", 64'(ener_v[k]), 64'(e.ener));
        end
      end
    end
  end

  task automatic run(input int inst, input logic [11:0] base, input logic [7:0] lf,
                     input logic [7:0] lmin, input logic [7:0] lmax, input logic [7:0] lstep,
                     input exp_t e, input int bound, input int reads, input int mid_start);
    int   d0, r0, cyc;
    logic seen;
    d0 = done_cnt_v[inst];
    r0 = rd_cnt_v[inst];
    sig_base = base;
    l_frame  = lf;
    lag_min  = lmin;
    lag_max  = lmax;
    lag_step = lstep;
    exp_q.push_back(e);
    @(posedge clk); #1 start_v[inst] = 1'b1;
    @(posedge clk); #1 start_v[inst] = 1'b0;
    // Inputs change after the start cycle; the run must not notice.
    sig_base = ~base;
    l_frame  = 8'd1;
    lag_min  = 8'd0;
    lag_max  = 8'd200;
    lag_step = 8'd7;
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < bound + 20) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1 && !e.err) check("busy_after_start", 64'(busy_v[inst]), 64'd1);
      if (cyc == mid_start) start_v[inst] = 1'b1;
      if (cyc == mid_start + 1) start_v[inst] = 1'b0;
      if (done_v[inst]) seen = 1'b1;
    end
    start_v[inst] = 1'b0;
    if (!seen) begin
      n_checks++;
      $display("FAIL timeout: inst %0d gave no done within %0d cycles", inst, cyc);
      exp_q.delete();
      return;
    end
    check("latency_in_bound", 64'(cyc <= bound), 64'd1);
    check("busy_at_done",     64'(busy_v[inst]), 64'd0);
    repeat ((mid_start != 0) ? 150 : 4) @(negedge clk);
    check("done_count",    64'(done_cnt_v[inst] - d0), 64'd1);
    check("read_count",    64'(rd_cnt_v[inst] - r0),   64'(reads));
    check("read_protocol", 64'(proto_v[inst]),          64'd0);
  endtask

  initial begin
    int b1, b3, d0;
    b1 = bound_f(3, 4, 1);
    b3 = bound_f(3, 4, 3);
    reset    = 1'b1;
    sig_base = '0;
    l_frame  = '0;
    lag_min  = '0;
    lag_max  = '0;
    lag_step = '0;
    for (int k = 0; k < NI; k++) start_v[k] = 1'b0;
    fill(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy",     64'(busy_v[0]),    64'd0);
    check("rst_done",     64'(done_v[0]),    64'd0);
    check("rst_err",      64'(err_v[0]),     64'd0);
    check("rst_rd_en",    64'(rd_en_v[0]),   64'd0);
    check("rst_rd_addr",  64'(rd_addr_v[0]), 64'd0);
    check("rst_cor_max",  64'(cor_v[0]),     64'h8000_0000);
    check("rst_p_max",    64'(p_v[0]),       64'd0);
    check("rst_ener_max", 64'(ener_v[0]),    64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Sparse pattern: lag 3 aligns the single nonzero x with a nonzero y.
    fill(0);
    run(0, 12'd16, 8'd4, 8'd2, 8'd4, 8'd1, mk(0, 1'b0, 32'd2000000, 8'd3, 32'd2000000), b1, 28, 0);

    // All-zero frame: every lag ties at 0.
    fill(1);
    run(0, 12'd16, 8'd4, 8'd2, 8'd4, 8'd1, mk(0, 1'b0, 32'd0, 8'd2, 32'd0), b1, 28, 0);
    run(1, 12'd16, 8'd4, 8'd2, 8'd4, 8'd1, mk(1, 1'b0, 32'd0, 8'd4, 32'd0), b1, 28, 0);

    // All -32768: every product clamps, sums saturate.
    fill(2);
    run(0, 12'd16, 8'd4, 8'd2, 8'd4, 8'd1,
        mk(0, 1'b0, 32'h7FFF_FFFF, 8'd2, 32'h7FFF_FFFF), b1, 28, 0);

    // Invalid configurations: reported the cycle after start, no reads.
    fill(0);
    run(0, 12'd16, 8'd4, 8'd5, 8'd3, 8'd1, mk(0, 1'b1, 32'h8000_0000, 8'd3, 32'd0), 1, 0, 0);
    run(0, 12'd16, 8'd0, 8'd2, 8'd4, 8'd1, mk(0, 1'b1, 32'h8000_0000, 8'd4, 32'd0), 1, 0, 0);
    run(0, 12'd16, 8'd4, 8'd2, 8'd4, 8'd0, mk(0, 1'b1, 32'h8000_0000, 8'd4, 32'd0), 1, 0, 0);

    // Base near zero: delayed addresses wrap to the top of memory.
    run(0, 12'd1, 8'd4, 8'd2, 8'd4, 8'd1, mk(0, 1'b0, 32'd2000000, 8'd3, 32'd4000000), b1, 28, 0);

    // Reset 10 cycles into a run aborts it silently.
    d0 = done_cnt_v[0];
    sig_base = 12'd16;
    l_frame  = 8'd4;
    lag_min  = 8'd2;
    lag_max  = 8'd4;
    lag_step = 8'd1;
    @(posedge clk); #1 start_v[0] = 1'b1;
    @(posedge clk); #1 start_v[0] = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_busy",  64'(busy_v[0]),  64'd0);
    check("abort_rd_en", 64'(rd_en_v[0]), 64'd0);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    check("abort_no_done", 64'(done_cnt_v[0] - d0), 64'd0);

    // Restart after abort, with a stray start pulse mid-run.
    run(0, 12'd16, 8'd4, 8'd2, 8'd4, 8'd1, mk(0, 1'b0, 32'd2000000, 8'd3, 32'd2000000), b1, 28, 20);

    // RD_LAT=3, step 2 over 7..2: lags 7, 5, 3 evaluated.
    run(2, 12'd16, 8'd4, 8'd2, 8'd7, 8'd2, mk(2, 1'b0, 32'd2000000, 8'd3, 32'd2000000), b3, 28, 0);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
